// File: rtl/knap_search.sv
// Exhaustive 0/1 knapsack subset search over a small configurable item table.
// Optional KNAP_FEASIBLE_CNT_EN enables the saturating feasible-subset counter.
//
// state | meaning
// IDLE  | waiting for start; results from last search held
// SCAN  | issuing one subset mask per cycle, ascending
// DRAIN | flushing the sum/compare pipeline after the last mask
// DONE  | one-cycle completion, done asserted
module knap_search #(
   parameter int N_ITEMS = 5,
   parameter int VAL_W   = 8,
   parameter int WT_W    = 8,
   localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [IDX_W-1:0]    cfg_idx,
   input  logic [VAL_W-1:0]    cfg_value,
   input  logic [WT_W-1:0]     cfg_weight,
   input  logic [VAL_W+4:0]    min_value,
   input  logic [WT_W+4:0]     max_weight,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                best_found,
   output logic [N_ITEMS-1:0]  best_mask,
   output logic [VAL_W+4:0]    best_value,
   output logic [WT_W+4:0]     best_weight,
   output logic [N_ITEMS:0]    feasible_cnt
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t               state;
   logic [VAL_W-1:0]     val_tab [N_ITEMS];
   logic [WT_W-1:0]      wt_tab  [N_ITEMS];
   logic [N_ITEMS-1:0]   cnt;
   logic [N_ITEMS-1:0]   mask_q;
   logic [N_ITEMS-1:0]   tot_mask;
   logic                 vld_iss;
   logic                 vld_sum;
   logic [VAL_W+4:0]     min_q;
   logic [WT_W+4:0]      max_q;
   logic [VAL_W+4:0]     sum_v;
   logic [WT_W+4:0]      sum_w;
   logic [VAL_W+4:0]     tot_v;
   logic [WT_W+4:0]      tot_w;
   logic                 feas;
   logic                 better;
   logic                 start_ok;

   assign start_ok = (state == IDLE) && start;

   // Table is frozen while a search runs; indices past N_ITEMS match no entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            val_tab[i] <= '0;
            wt_tab[i]  <= '0;
         end
      end else if (cfg_we && !busy) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            if (cfg_idx == IDX_W'(i)) begin
               val_tab[i] <= cfg_value;
               wt_tab[i]  <= cfg_weight;
            end
         end
      end
   end

   always_comb begin
      sum_v = '0;
      sum_w = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (mask_q[i]) begin
            sum_v = sum_v + {5'd0, val_tab[i]};
            sum_w = sum_w + {5'd0, wt_tab[i]};
         end
      end
   end

   // Strict improvement only, so among full ties the earlier (lower) mask wins.
   always_comb begin
      feas   = vld_sum && (tot_v >= min_q) && (tot_w <= max_q);
      better = !best_found || (tot_v > best_value) ||
               ((tot_v == best_value) && (tot_w < best_weight));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         cnt         <= '0;
         mask_q      <= '0;
         tot_mask    <= '0;
         vld_iss     <= 1'b0;
         vld_sum     <= 1'b0;
         min_q       <= '0;
         max_q       <= '0;
         tot_v       <= '0;
         tot_w       <= '0;
         best_found  <= 1'b0;
         best_mask   <= '0;
         best_value  <= '0;
         best_weight <= '0;
      end else begin
         done     <= 1'b0;
         tot_v    <= sum_v;
         tot_w    <= sum_w;
         tot_mask <= mask_q;
         vld_sum  <= vld_iss;
         if (feas && better) begin
            best_found  <= 1'b1;
            best_mask   <= tot_mask;
            best_value  <= tot_v;
            best_weight <= tot_w;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= SCAN;
                  busy        <= 1'b1;
                  min_q       <= min_value;
                  max_q       <= max_weight;
                  cnt         <= '0;
                  vld_iss     <= 1'b0;
                  vld_sum     <= 1'b0;
                  best_found  <= 1'b0;
                  best_mask   <= '0;
                  best_value  <= '0;
                  best_weight <= '0;
               end
            end
            SCAN: begin
               mask_q  <= cnt;
               vld_iss <= 1'b1;
               if (&cnt) begin
                  state <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               vld_iss <= 1'b0;
               if (vld_sum && !vld_iss) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef KNAP_FEASIBLE_CNT_EN
   logic [N_ITEMS:0] fcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= '0;
      end else if (start_ok) begin
         fcnt <= '0;
      end else if (feas && !(&fcnt)) begin
         fcnt <= fcnt + 1'b1;
      end
   end

   assign feasible_cnt = fcnt;
`else
   assign feasible_cnt = '0;
`endif

endmodule

// File: tb/tb_knap_search.sv
// Directed + randomized bench for knap_search, checked against an exhaustive subset model.
module tb_knap_search;
   localparam int N   = 5;
   localparam int NM  = 1 << N;
   localparam int LAT = NM + 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_idx = '0;
   logic [7:0]  cfg_value = '0;
   logic [7:0]  cfg_weight = '0;
   logic [12:0] min_value = '0;
   logic [12:0] max_weight = '0;
   logic        start = 1'b0;
   logic        busy, done, best_found;
   logic [4:0]  best_mask;
   logic [12:0] best_value, best_weight;
   logic [5:0]  feasible_cnt;

   int passed = 0;
   int total  = 0;
   int mv [N];
   int mw [N];

   knap_search #(.N_ITEMS(N), .VAL_W(8), .WT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_value(cfg_value), .cfg_weight(cfg_weight), .min_value(min_value),
      .max_weight(max_weight), .start(start), .busy(busy), .done(done),
      .best_found(best_found), .best_mask(best_mask), .best_value(best_value),
      .best_weight(best_weight), .feasible_cnt(feasible_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Enumerate every subset; best = highest value, then lowest weight, then lowest mask.
   task automatic model(input int mn, input int mx, output int f, output int m,
                        output int v, output int w, output int c);
      int sv, sw;
      f = 0; m = 0; v = 0; w = 0; c = 0;
      for (int s = 0; s < NM; s++) begin
         sv = 0;
         sw = 0;
         for (int i = 0; i < N; i++) begin
            if (((s >> i) & 1) == 1) begin
               sv += mv[i];
               sw += mw[i];
            end
         end
         if (sv >= mn && sw <= mx) begin
            c++;
            if (f == 0 || sv > v || (sv == v && sw < w)) begin
               f = 1; m = s; v = sv; w = sw;
            end
         end
      end
`ifndef KNAP_FEASIBLE_CNT_EN
      c = 0;
`endif
   endtask

   task automatic load_table();
      for (int i = 0; i < N; i++) begin
         cfg_we = 1'b1; cfg_idx = 3'(i);
         cfg_value = 8'(mv[i]); cfg_weight = 8'(mw[i]);
         @(posedge clk); #1;
      end
      for (int i = N; i < 8; i++) begin
         cfg_we = 1'b1; cfg_idx = 3'(i);
         cfg_value = 8'd255; cfg_weight = 8'd0;
         @(posedge clk); #1;
      end
      cfg_we = 1'b0;
   endtask

   task automatic run_search(input string tag, input int mn, input int mx, input bit poke);
      int cyc, f, m, v, w, c;
      model(mn, mx, f, m, v, w, c);
      min_value = 13'(mn); max_weight = 13'(mx); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < LAT + 20) begin
         @(posedge clk); #1;
         cyc++;
         if (poke && cyc == 10) begin
            start = 1'b1; min_value = 13'd0; max_weight = 13'd8191;
            cfg_we = 1'b1; cfg_idx = 3'd0; cfg_value = 8'd99; cfg_weight = 8'd0;
         end
         if (poke && cyc == 11) begin
            start = 1'b0; cfg_we = 1'b0;
         end
         if (cyc == 5) chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(LAT));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      chk({tag, "_found"}, 32'(best_found), 32'(f));
      chk({tag, "_mask"}, 32'(best_mask), 32'(m));
      chk({tag, "_value"}, 32'(best_value), 32'(v));
      chk({tag, "_weight"}, 32'(best_weight), 32'(w));
      chk({tag, "_fcnt"}, 32'(feasible_cnt), 32'(c));
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_hold_mask"}, 32'(best_mask), 32'(m));
   endtask

   task automatic set_req31();
      mv[0] = 4;  mw[0] = 12;
      mv[1] = 2;  mw[1] = 1;
      mv[2] = 2;  mw[2] = 2;
      mv[3] = 1;  mw[3] = 1;
      mv[4] = 10; mw[4] = 4;
   endtask

   initial begin
      int seen;
      int mn, mx;
      for (int i = 0; i < N; i++) begin mv[i] = 0; mw[i] = 0; end

      // Reset state
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_found", 32'(best_found), 32'd0);
      chk("rst_mask", 32'(best_mask), 32'd0);
      chk("rst_value", 32'(best_value), 32'd0);
      chk("rst_fcnt", 32'(feasible_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reference table, single feasible subset
      set_req31();
      load_table();
      run_search("req31", 15, 16, 1'b0);
      chk("req31_mask_lit", 32'(best_mask), 32'h1E);
      chk("req31_value_lit", 32'(best_value), 32'd15);
      chk("req31_weight_lit", 32'(best_weight), 32'd8);

      // Threshold just above reachable -> nothing feasible
      run_search("req32", 16, 16, 1'b0);
      chk("req32_found_lit", 32'(best_found), 32'd0);

      // Full tie keeps lower mask
      mv[0] = 5; mw[0] = 3; mv[1] = 5; mw[1] = 3;
      for (int i = 2; i < N; i++) begin mv[i] = 0; mw[i] = 9; end
      load_table();
      run_search("tie", 5, 3, 1'b0);
      chk("tie_mask_lit", 32'(best_mask), 32'h01);

      // Empty subset is the only candidate when min is 0 and nothing fits
      run_search("empty", 0, 2, 1'b0);

      // start/cfg_we mid-scan must be ignored
      set_req31();
      load_table();
      run_search("poke", 15, 16, 1'b1);
      chk("poke_mask_lit", 32'(best_mask), 32'h1E);

      // Asynchronous reset mid-scan
      min_value = 13'd15; max_weight = 13'd16; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_found", 32'(best_found), 32'd0);
      for (int i = 0; i < N; i++) begin mv[i] = 0; mw[i] = 0; end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      run_search("cleared_tab", 15, 16, 1'b0);
      set_req31();
      load_table();
      run_search("reloaded", 15, 16, 1'b0);

      // Randomized tables: small ranges provoke ties, full ranges exercise wide sums
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++) begin
            if (k < 4) begin
               mv[i] = int'($urandom_range(0, 3));
               mw[i] = int'($urandom_range(0, 3));
            end else begin
               mv[i] = int'($urandom_range(0, 255));
               mw[i] = int'($urandom_range(0, 255));
            end
         end
         if (k < 4) begin
            mn = int'($urandom_range(0, 5));
            mx = int'($urandom_range(0, 7));
         end else begin
            mn = int'($urandom_range(0, 700));
            mx = int'($urandom_range(0, 800));
         end
         load_table();
         run_search("rnd", mn, mx, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/knap_search.md
KNAP_SEARCH -- requirements
Module: knap_search

Interface
REQ-001 SHALL have parameter N_ITEMS, default 5, meaning item count; legal range 1..16.
REQ-002 SHALL have parameter VAL_W, default 8, meaning per-item value width.
REQ-003 SHALL have parameter WT_W, default 8, meaning per-item weight width.
REQ-004 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port cfg_we  in  1  item table write strobe.
REQ-007 SHALL have port cfg_idx  in  clog2(N_ITEMS) (min 1)  item index to write.
REQ-008 SHALL have port cfg_value  in  VAL_W  item value.
REQ-009 SHALL have port cfg_weight  in  WT_W  item weight.
REQ-010 SHALL have port min_value  in  VAL_W+5  value threshold, latched at start.
REQ-011 SHALL have port max_weight  in  WT_W+5  weight limit, latched at start.
REQ-012 SHALL have port start  in  1  begin exhaustive search.
REQ-013 SHALL have port busy  out  1  search in progress.
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port best_found  out  1  a feasible subset exists.
REQ-016 SHALL have port best_mask  out  N_ITEMS  best subset; bit i selects item i.
REQ-017 SHALL have ports best_value  out  VAL_W+5 and best_weight  out  WT_W+5  best subset totals.
REQ-018 SHALL have port feasible_cnt  out  N_ITEMS+1  number of feasible subsets.

Function
REQ-019 SHALL hold an N_ITEMS-entry value/weight table; cfg_we writes entry cfg_idx next edge; writes while busy and out-of-range indices are ignored.
REQ-020 SHALL implement states IDLE, SCAN, DRAIN, DONE; start in IDLE -> SCAN, latching min_value/max_weight, clearing mask counter, best_* and feasible_cnt.
REQ-021 SCAN SHALL issue one mask per cycle, 0 to 2^N_ITEMS-1 ascending; after issuing all-ones -> DRAIN (no wrap); DRAIN -> DONE -> IDLE.
REQ-022 Totals for each mask SHALL be summed at full width (no overflow for N_ITEMS<=16) and registered; comparison occurs one cycle after issue, so DRAIN evaluates the last mask.
REQ-023 A subset is feasible iff total_value >= min_value and total_weight <= max_weight; empty mask is feasible only when min_value is 0.
REQ-024 Best SHALL be replaced iff feasible and (none found yet, or value > best_value, or value == best_value and weight < best_weight); full ties keep the lower mask.
REQ-025 busy SHALL be 1 in SCAN and DRAIN; done SHALL be 1 only in DONE, exactly 2^N_ITEMS+2 edges after the edge sampling start.
REQ-026 start outside IDLE SHALL be ignored; results SHALL hold from DONE until the next accepted start.
REQ-027 With no feasible subset, best_found, best_mask, best_value, best_weight SHALL be 0 at done.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and zero all outputs, table entries, latched limits and counters, including mid-SCAN; no done pulse for an aborted search.

Configuration
REQ-029 Macro KNAP_FEASIBLE_CNT_EN defined: feasible_cnt increments per feasible subset evaluated, saturating at all-ones.
REQ-030 Macro KNAP_FEASIBLE_CNT_EN undefined: feasible_cnt port remains, tied to 0, no counter logic.

Verification
REQ-031 Table (4,12),(2,1),(2,2),(1,1),(10,4), min 15, max 16, start -> done 34 cycles later, best_found 1, best_mask 0x1E, best_value 15, best_weight 8, feasible_cnt 1 (macro on).
REQ-032 Same table, min 16 -> best_found 0, best_mask 0, best_value 0, feasible_cnt 0.
REQ-033 Items 0 and 1 both (5,3), others (0,9), min 5, max 3 -> best_mask 0x01 (tie keeps lower mask).
REQ-034 rst_n low at cycle 10 of SCAN -> busy 0 asynchronously, no done; fresh start gives correct REQ-031 result only after table reload.
REQ-035 start and cfg_we pulsed mid-SCAN -> ignored; done timing and result identical to REQ-031.
